// File: rtl/lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        WAIT_RVALID
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    function automatic logic [7:0] size_mask(input logic [1:0] size);
        logic [7:0] m;
        case (size)
            2'b00:   m = 8'h01;
            2'b01:   m = 8'h03;
            2'b10:   m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts the addressed bytes from a doubleword read and sign/zero extends them.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [63:0] rdata_i,
    input  logic [2:0]  offset_i,
    input  logic [2:0]  funct3_i,
    output logic [63:0] data_o
);

    logic [63:0] shifted;

    always_comb begin
        shifted = rdata_i >> {offset_i, 3'b000};
        case (funct3_i)
            F3_LB:   data_o = {{56{shifted[7]}},  shifted[7:0]};
            F3_LH:   data_o = {{48{shifted[15]}}, shifted[15:0]};
            F3_LW:   data_o = {{32{shifted[31]}}, shifted[31:0]};
            F3_LD:   data_o = shifted;
            F3_LBU:  data_o = {56'd0, shifted[7:0]};
            F3_LHU:  data_o = {48'd0, shifted[15:0]};
            F3_LWU:  data_o = {32'd0, shifted[31:0]};
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: issues req/gnt/rvalid data-memory accesses, aligns store
// data, extracts load data and stalls the front end while an access is in flight.
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int BE_W = XLEN / 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic [XLEN-1:0] ex_res_i,
    input  logic [XLEN-1:0] store_data_i,
    input  logic [2:0]      funct3_i,
    input  logic            memread_i,
    input  logic            memwrite_i,
    input  logic [4:0]      rd_i,
    input  logic            regwrite_i,
    input  logic            memtoreg_i,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    output logic [BE_W-1:0] dmem_be_o,
    input  logic            dmem_gnt_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic            stall_o,
    output logic            misaligned_o,
    output logic [XLEN-1:0] mem_data_o,
    output logic [XLEN-1:0] ex_res_o,
    output logic [4:0]      rd_o,
    output logic            regwrite_o,
    output logic            memtoreg_o
);

    lsu_state_e state_q, state_d;

    logic [2:0]      offset;
    logic            is_access;
    logic            is_load;
    logic            illegal;
    logic            aligned;
    logic            load_done;
    logic [XLEN-1:0] load_data;

    assign offset    = ex_res_i[2:0];
    assign is_access = valid_i & (memread_i | memwrite_i);
    // A slot flagged as both load and store is handled as a load.
    assign is_load   = memread_i;
    assign illegal   = is_load ? (funct3_i == 3'b111) : funct3_i[2];

    always_comb begin
        case (funct3_i[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~offset[0];
            2'b10:   aligned = (offset[1:0] == 2'b00);
            default: aligned = (offset == 3'b000);
        endcase
    end

    lsu_load_align u_load_align (
        .rdata_i  (dmem_rdata_i),
        .offset_i (offset),
        .funct3_i (funct3_i),
        .data_o   (load_data)
    );

    always_comb begin
        state_d      = state_q;
        dmem_req_o   = 1'b0;
        stall_o      = 1'b0;
        misaligned_o = 1'b0;
        load_done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_access) begin
                    if (illegal || !aligned) begin
                        misaligned_o = 1'b1;
                    end else begin
                        dmem_req_o = 1'b1;
                        if (!dmem_gnt_i) begin
                            state_d = WAIT_GNT;
                            stall_o = 1'b1;
                        end else if (is_load) begin
                            state_d = WAIT_RVALID;
                            stall_o = 1'b1;
                        end
                    end
                end
            end
            WAIT_GNT: begin
                dmem_req_o = 1'b1;
                stall_o    = 1'b1;
                if (dmem_gnt_i) begin
                    if (is_load) begin
                        state_d = WAIT_RVALID;
                    end else begin
                        state_d = IDLE;
                        stall_o = 1'b0;
                    end
                end
            end
            WAIT_RVALID: begin
                stall_o = 1'b1;
                if (dmem_rvalid_i) begin
                    stall_o   = 1'b0;
                    load_done = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Reset forces every control output low even though they are combinational.
        if (rst_i) begin
            state_d      = IDLE;
            dmem_req_o   = 1'b0;
            stall_o      = 1'b0;
            misaligned_o = 1'b0;
            load_done    = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign dmem_we_o    = memwrite_i & ~memread_i;
    assign dmem_addr_o  = {ex_res_i[XLEN-1:3], 3'b000};
    assign dmem_wdata_o = store_data_i << {offset, 3'b000};
    assign dmem_be_o    = size_mask(funct3_i[1:0]) << offset;

    assign mem_data_o = load_done ? load_data : '0;
    assign ex_res_o   = ex_res_i;
    assign rd_o       = rd_i;
    assign memtoreg_o = memtoreg_i;
    assign regwrite_o = regwrite_i & valid_i & ~stall_o & ~misaligned_o & ~rst_i;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed and randomized checks of mem_stage_lsu against a transaction-level timeline model.
module tb_mem_stage_lsu;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [63:0] ex_res_i;
    logic [63:0] store_data_i;
    logic [2:0]  funct3_i;
    logic        memread_i;
    logic        memwrite_i;
    logic [4:0]  rd_i;
    logic        regwrite_i;
    logic        memtoreg_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [63:0] dmem_addr_o;
    logic [63:0] dmem_wdata_o;
    logic [7:0]  dmem_be_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [63:0] dmem_rdata_i;
    logic        stall_o;
    logic        misaligned_o;
    logic [63:0] mem_data_o;
    logic [63:0] ex_res_o;
    logic [4:0]  rd_o;
    logic        regwrite_o;
    logic        memtoreg_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    mem_stage_lsu #(.XLEN(64), .BE_W(8)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .valid_i       (valid_i),
        .ex_res_i      (ex_res_i),
        .store_data_i  (store_data_i),
        .funct3_i      (funct3_i),
        .memread_i     (memread_i),
        .memwrite_i    (memwrite_i),
        .rd_i          (rd_i),
        .regwrite_i    (regwrite_i),
        .memtoreg_i    (memtoreg_i),
        .dmem_req_o    (dmem_req_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_wdata_o  (dmem_wdata_o),
        .dmem_be_o     (dmem_be_o),
        .dmem_gnt_i    (dmem_gnt_i),
        .dmem_rvalid_i (dmem_rvalid_i),
        .dmem_rdata_i  (dmem_rdata_i),
        .stall_o       (stall_o),
        .misaligned_o  (misaligned_o),
        .mem_data_o    (mem_data_o),
        .ex_res_o      (ex_res_o),
        .rd_o          (rd_o),
        .regwrite_o    (regwrite_o),
        .memtoreg_o    (memtoreg_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One memory instruction held in EX/MEM until the modelled completion cycle.
    // Grant arrives gd cycles after the first request cycle; rvalid rdl cycles after grant.
    task automatic do_mem(input bit ld, input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] sd, input logic [63:0] rdat,
                          input int gd, input int rdl, input bit rw);
        int          n;
        int          off;
        int          last;
        bit          bad_acc;
        bit          exp_stall;
        logic [63:0] exp_be;
        logic [63:0] exp_wd;
        logic [63:0] exp_ld;
        logic [4:0]  rd;
        n       = 1 << f3[1:0];
        off     = int'(addr[2:0]);
        bad_acc = ((off % n) != 0) || (ld ? (f3 == 3'b111) : f3[2]);
        exp_be  = (((64'd1 << n) - 64'd1) << off) & 64'hFF;
        exp_wd  = sd << (8 * off);
        exp_ld  = '0;
        for (int i = 0; i < n; i++)
            exp_ld |= ((rdat >> (8 * (off + i))) & 64'hFF) << (8 * i);
        if (!f3[2] && n < 8 && exp_ld[8*n-1])
            exp_ld |= ~64'd0 << (8 * n);
        last = ld ? gd + rdl : gd;
        rd   = 5'($urandom_range(1, 31));

        if (bad_acc) begin
            @(negedge clk_i);
            valid_i = 1'b1; ex_res_i = addr; store_data_i = sd; funct3_i = f3;
            memread_i = ld; memwrite_i = ~ld; rd_i = rd; regwrite_i = rw; memtoreg_i = ld;
            dmem_gnt_i = 1'($urandom_range(0, 1)); dmem_rvalid_i = 1'($urandom_range(0, 1));
            dmem_rdata_i = rdat;
            #2;
            chk("mis_flag", 64'(misaligned_o), 64'd1);
            chk("mis_req", 64'(dmem_req_o), 64'd0);
            chk("mis_stall", 64'(stall_o), 64'd0);
            chk("mis_regwrite", 64'(regwrite_o), 64'd0);
            return;
        end

        for (int c = 0; c <= last; c++) begin
            @(negedge clk_i);
            valid_i = 1'b1; ex_res_i = addr; store_data_i = sd; funct3_i = f3;
            memread_i  = ld;
            memwrite_i = ld ? 1'($urandom_range(0, 1)) : 1'b1;
            rd_i = rd; regwrite_i = rw; memtoreg_i = ld; dmem_rdata_i = rdat;
            if (c == gd)      dmem_gnt_i = 1'b1;
            else if (c > gd)  dmem_gnt_i = 1'($urandom_range(0, 1));
            else              dmem_gnt_i = 1'b0;
            if (ld && c == last) dmem_rvalid_i = 1'b1;
            else if (c <= gd)    dmem_rvalid_i = 1'($urandom_range(0, 1));
            else                 dmem_rvalid_i = 1'b0;
            #2;
            exp_stall = (c != last);
            chk("stall", 64'(stall_o), 64'(exp_stall));
            chk("misaligned", 64'(misaligned_o), 64'd0);
            chk("req", 64'(dmem_req_o), 64'(c <= gd));
            chk("regwrite", 64'(regwrite_o), 64'(rw && !exp_stall));
            if (c <= gd) begin
                chk("addr", dmem_addr_o, {addr[63:3], 3'b000});
                chk("be", 64'(dmem_be_o), exp_be);
                chk("we", 64'(dmem_we_o), 64'(!ld));
                if (!ld) chk("wdata", dmem_wdata_o, exp_wd);
            end
            if (c == last) begin
                chk("mem_data", mem_data_o, ld ? exp_ld : 64'd0);
                chk("rd_pass", 64'(rd_o), 64'(rd));
                chk("ex_res_pass", ex_res_o, addr);
                chk("memtoreg_pass", 64'(memtoreg_o), 64'(ld));
            end
        end
    endtask

    initial begin
        rst_i = 1'b1; valid_i = 1'b0; ex_res_i = '0; store_data_i = '0; funct3_i = '0;
        memread_i = 1'b0; memwrite_i = 1'b0; rd_i = '0; regwrite_i = 1'b0; memtoreg_i = 1'b0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;

        // Reset: drive a would-be access and confirm everything stays quiet.
        @(negedge clk_i);
        valid_i = 1'b1; memread_i = 1'b1; regwrite_i = 1'b1; ex_res_i = 64'h100;
        #2;
        chk("rst_req", 64'(dmem_req_o), 64'd0);
        chk("rst_stall", 64'(stall_o), 64'd0);
        chk("rst_mis", 64'(misaligned_o), 64'd0);
        chk("rst_regwrite", 64'(regwrite_o), 64'd0);
        @(negedge clk_i);
        valid_i = 1'b0; memread_i = 1'b0; rst_i = 1'b0;

        // Directed scenarios.
        do_mem(1'b0, 3'b011, 64'h1000, 64'h1122334455667788, '0, 0, 0, 1'b0);
        do_mem(1'b0, 3'b000, 64'h1003, 64'h00000000000000AB, '0, 3, 0, 1'b0);
        do_mem(1'b1, 3'b000, 64'h2005, 64'h0000800000000000, 64'h0000800000000000, 0, 1, 1'b1);
        do_mem(1'b1, 3'b100, 64'h2005, 64'h0, 64'h0000800000000000, 0, 1, 1'b1);
        do_mem(1'b1, 3'b010, 64'h3002, 64'h0, 64'h0, 0, 1, 1'b1);
        do_mem(1'b1, 3'b111, 64'h3000, 64'h0, 64'h0, 0, 1, 1'b1);
        do_mem(1'b0, 3'b100, 64'h3000, 64'h0, 64'h0, 0, 0, 1'b0);
        do_mem(1'b1, 3'b001, 64'h4006, 64'h0, 64'h8001_0000_0000_0000, 2, 3, 1'b1);

        // Reset while waiting for rvalid; a late rvalid must be ignored.
        @(negedge clk_i);
        valid_i = 1'b1; ex_res_i = 64'h5000; funct3_i = 3'b011; memread_i = 1'b1;
        memwrite_i = 1'b0; regwrite_i = 1'b1; memtoreg_i = 1'b1; rd_i = 5'd7;
        dmem_gnt_i = 1'b1; dmem_rvalid_i = 1'b0; dmem_rdata_i = 64'hDEADBEEF_CAFEF00D;
        #2;
        chk("rr_req", 64'(dmem_req_o), 64'd1);
        chk("rr_stall0", 64'(stall_o), 64'd1);
        @(negedge clk_i);
        dmem_gnt_i = 1'b0;
        #1;
        chk("rr_stall1", 64'(stall_o), 64'd1);
        chk("rr_regwrite1", 64'(regwrite_o), 64'd0);
        rst_i = 1'b1;
        #1;
        chk("rr_stall_rst", 64'(stall_o), 64'd0);
        chk("rr_req_rst", 64'(dmem_req_o), 64'd0);
        chk("rr_regwrite_rst", 64'(regwrite_o), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0; valid_i = 1'b0; dmem_rvalid_i = 1'b1;
        #2;
        chk("rr_late_stall", 64'(stall_o), 64'd0);
        chk("rr_late_regwrite", 64'(regwrite_o), 64'd0);
        chk("rr_late_data", mem_data_o, 64'd0);
        @(negedge clk_i);
        dmem_rvalid_i = 1'b0;
        valid_i = 1'b1; memread_i = 1'b0; memwrite_i = 1'b0; memtoreg_i = 1'b0;
        regwrite_i = 1'b1; ex_res_i = 64'h42; rd_i = 5'd3;
        #2;
        chk("add_ex_res", ex_res_o, 64'h42);
        chk("add_regwrite", 64'(regwrite_o), 64'd1);
        chk("add_req", 64'(dmem_req_o), 64'd0);
        chk("add_stall", 64'(stall_o), 64'd0);
        chk("add_mem_data", mem_data_o, 64'd0);
        chk("add_rd", 64'(rd_o), 64'd3);

        // Randomized mix of loads/stores, sizes, offsets and bus latencies.
        for (int t = 0; t < 60; t++) begin
            logic [63:0] a;
            logic [63:0] d;
            logic [63:0] r;
            bit          ld;
            a  = {$urandom, $urandom};
            d  = {$urandom, $urandom};
            r  = {$urandom, $urandom};
            ld = 1'($urandom_range(0, 1));
            do_mem(ld, 3'($urandom_range(0, 7)), a, d, r,
                   $urandom_range(0, 3), $urandom_range(1, 3), 1'($urandom_range(0, 1)));
        end

        @(negedge clk_i);
        valid_i = 1'b0; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
        #2;
        chk("end_stall", 64'(stall_o), 64'd0);
        chk("end_req", 64'(dmem_req_o), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-access (MEM) stage of the 5-stage RV64 pipeline; sits between the EX/MEM pipeline latch and the MEM/WB pipeline latch.
- Turns EX results into data-memory requests on a req/gnt/rvalid bus.
- Aligns store data and byte enables; extracts and extends load data.
- Stalls the front of the pipeline while an access is outstanding and inserts a write-back bubble until the access completes.

Parameters:
- XLEN, 64, datapath and address width; only 64 is supported.
- BE_W, XLEN/8, number of byte-enable lanes.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- valid_i  in  1  EX/MEM slot holds a real instruction.
- ex_res_i  in  64  ALU result; byte address for memory ops.
- store_data_i  in  64  rs2 value for stores.
- funct3_i  in  3  access size/sign (RV64 load/store encoding).
- memread_i  in  1  instruction is a load.
- memwrite_i  in  1  instruction is a store.
- rd_i  in  5  destination register.
- regwrite_i  in  1  write-back enable.
- memtoreg_i  in  1  select memory data at WB.
- dmem_req_o  out  1  bus request.
- dmem_we_o  out  1  1 = write.
- dmem_addr_o  out  64  doubleword-aligned address {ex_res_i[63:3],3'b000}.
- dmem_wdata_o  out  64  lane-shifted store data.
- dmem_be_o  out  8  byte enables.
- dmem_gnt_i  in  1  request accepted.
- dmem_rvalid_i  in  1  read data valid.
- dmem_rdata_i  in  64  read data.
- stall_o  out  1  freeze PC, IF/ID and ID/EX, and hold EX/MEM.
- misaligned_o  out  1  one-cycle misaligned/illegal-access flag.
- mem_data_o  out  64  extended load data, to the MEM/WB latch.
- ex_res_o  out  64  ex_res_i passed through.
- rd_o  out  5  rd_i passed through.
- regwrite_o  out  1  gated write-back enable.
- memtoreg_o  out  1  memtoreg_i passed through.

Behaviour:
- Only the FSM state is registered; all outputs are combinational from state and inputs.
- Reset: while rst_i=1 the state is IDLE, and dmem_req_o, stall_o, misaligned_o and regwrite_o are all 0.
- States and transitions:
  - IDLE
    - Memory op = valid_i & (memread_i|memwrite_i) & aligned.
    - On a memory op, drive dmem_req_o=1 in the same cycle.
    - Store with gnt: done, stall_o=0, stay IDLE.
    - Load with gnt: go to WAIT_RVALID, stall_o=1.
    - No gnt: go to WAIT_GNT, stall_o=1.
  - WAIT_GNT
    - req=1, stall=1; EX/MEM inputs are stable because they are held by the stall.
    - On gnt, a store completes (stall_o=0 this cycle, go to IDLE); a load goes to WAIT_RVALID.
  - WAIT_RVALID
    - req=0, stall=1.
    - On dmem_rvalid_i: stall_o=0, mem_data_o = extracted dmem_rdata_i, go to IDLE. The MEM/WB latch captures on that edge.
- Bubble rule: regwrite_o = regwrite_i & valid_i & ~stall_o & ~misaligned_o.
- Latency:
  - Store: 0 extra cycles when gnt arrives with req.
  - Load: minimum 1 stall cycle (req+gnt in cycle 0, rvalid in cycle 1 ends the stall).
- Size/alignment by funct3[1:0]:
  - 00 byte: any address.
  - 01 half: addr[0]=0.
  - 10 word: addr[1:0]=0.
  - 11 double: addr[2:0]=0.
  - Illegal: store with funct3[2]=1, or load funct3=111.
- Misaligned/illegal access:
  - No request is issued.
  - misaligned_o=1 for that cycle, no stall, regwrite_o=0.
- Store alignment:
  - dmem_be_o = size mask (0x01/0x03/0x0F/0xFF) << addr[2:0].
  - dmem_wdata_o = store_data_i << (8*addr[2:0]).
  - dmem_we_o=1.
- Load extraction:
  - Shift dmem_rdata_i right by 8*addr[2:0], then extend.
  - funct3[2]=0 sign-extends; =1 zero-extends (LBU/LHU/LWU).
  - LD passes the value unchanged.
- Loads drive dmem_be_o = size mask << offset and dmem_we_o=0.
- Non-memory valid instruction: no req, no stall, fields pass through, mem_data_o=0.
- memread_i and memwrite_i both 1 is treated as a load.
- dmem_rvalid_i in IDLE or WAIT_GNT is ignored.
- dmem_gnt_i without a request is ignored.
- Reset mid-access: the state returns to IDLE immediately and req drops. A late rvalid after reset is ignored.

Decomposition:
- Package lsu_pkg:
  - State enum {IDLE, WAIT_GNT, WAIT_RVALID}.
  - funct3 constants LB..LWU, SB..SD.
  - Size-mask function.
- Sub-module lsu_load_align: combinational shift plus sign/zero extension. Inputs rdata, offset, funct3; output data.

Test Plan:
- SD at 0x1000, data 0x1122334455667788, gnt same cycle -> req=1, we=1, be=0xFF, addr 0x1000, stall_o never 1.
- SB at 0x1003, data 0xAB -> be=0x08, wdata byte 3 = 0xAB; with gnt delayed 3 cycles -> stall_o=1 for exactly 3 cycles and req held with stable addr/data.
- LB at 0x2005, rdata 0x0000_8000_0000_0000 (byte 5 = 0x80) -> mem_data_o=0xFFFF_FFFF_FFFF_FF80 on the rvalid cycle; LBU -> 0x80; regwrite_o=0 during the stall and 1 on the rvalid cycle.
- LW at 0x3002 -> misaligned_o=1 for one cycle, no req, regwrite_o=0, stall_o=0.
- Load granted, rst_i asserted before rvalid, rvalid after release -> state IDLE, stall_o=0, rvalid ignored, no spurious write-back.
- ADD with regwrite_i=1, ex_res 0x42 -> ex_res_o=0x42, regwrite_o=1, no req, no stall.
